conv_mem_slave: RTL and testbench

Word-organised memory responder for the convolution engine's master ports (`M0_*`, `M1_*`); one instance serves one port. It services byte-addressed read requests with a configurable registered read latency, applies byte-strobed writes, and counts accepted writes. Completion of the expected result image is flagged to the bench or SoC. A side-band preload port fills the array (image, kernel, bias) before `start`.

---
 rtl/conv_mem_slave.sv | 138 +++++++++++++
 tb/tb_conv_mem_slave.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mem_slave.sv
// conv_mem_slave: word-organised memory responder for one convolution-engine
// master port. Byte-strobed writes, a read pipeline of RD_LAT stages with
// read-first collision behaviour, a side-band preload port, a sticky error
// flag and a saturating accepted-write counter with a sticky done flag.
module conv_mem_slave #(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned EXPECT_WR = 676
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     R_req,
   input  logic [31:0]              addr,
   output logic [31:0]              R_data,
   input  logic [3:0]               W_req,
   input  logic [31:0]              W_data,
   input  logic                     ld_en,
   input  logic [$clog2(DEPTH)-1:0] ld_idx,
   input  logic [31:0]              ld_data,
   output logic                     err,
   output logic [15:0]              wr_count,
   output logic                     done
);

   localparam int unsigned IW = $clog2(DEPTH);

   logic [31:0]   mem_q [DEPTH];

   logic          addr_legal;
   logic [IW-1:0] widx;
   logic [31:0]   rd_word;
   logic [31:0]   rd_val;
   logic          bus_wr;
   logic          bus_wr_mem;
   logic [31:0]   bus_wdata;
   logic          ld_legal;
   logic          ld_wr;

   logic          err_q, err_d;
   logic [15:0]   wr_count_q, wr_count_d;
   logic          done_q, done_d;
   logic [31:0]   r_data_q, r_data_d;
   logic          last_vld;
   logic [31:0]   last_dat;

   // Address decode, byte merge, preload arbitration and status next-state
   always_comb begin
      addr_legal = (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < DEPTH);
      widx       = addr[IW+1:2];
      rd_word    = mem_q[widx];
      rd_val     = addr_legal ? rd_word : '0;
      bus_wr     = (W_req != 4'h0) && addr_legal;
      ld_legal   = 32'(ld_idx) < DEPTH;
      ld_wr      = ld_en && ld_legal;
      // A same-word preload wins; the bus write is still counted below.
      bus_wr_mem = bus_wr && !(ld_wr && (ld_idx == widx));
      bus_wdata  = rd_word;
      for (int unsigned b = 0; b < 4; b++) begin
         if (W_req[b]) bus_wdata[8*b +: 8] = W_data[8*b +: 8];
      end
      err_d = err_q
            | (((R_req) || (W_req != 4'h0)) && !addr_legal)
            | (ld_en && !ld_legal);
      wr_count_d = wr_count_q;
      if (bus_wr && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
      done_d = done_q | (32'(wr_count_d) >= EXPECT_WR);
   end

   // Array writes; the array itself is never cleared by reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (bus_wr_mem) mem_q[widx]   <= bus_wdata;
         if (ld_wr)      mem_q[ld_idx] <= ld_data;
      end
   end

   // The final pipeline stage is the R_data register itself (it holds when
   // no valid read arrives), so only RD_LAT-1 intermediate stages exist.
   if (RD_LAT == 1) begin : g_lat1
      always_comb begin
         last_vld = R_req;
         last_dat = rd_val;
      end
   end else begin : g_latn
      logic [RD_LAT-2:0] vld_q, vld_d;
      logic [31:0]       dat_q [RD_LAT-1];
      logic [31:0]       dat_d [RD_LAT-1];

      // Shift request valid/data through the intermediate stages
      always_comb begin
         vld_d[0] = R_req;
         dat_d[0] = rd_val;
         for (int unsigned i = 1; i < RD_LAT - 1; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
         end
         last_vld = vld_q[RD_LAT-2];
         last_dat = dat_q[RD_LAT-2];
      end

      // Intermediate stage registers; reset drops in-flight reads
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < RD_LAT - 1; i++) dat_q[i] <= '0;
         end else begin
            vld_q <= vld_d;
            for (int unsigned i = 0; i < RD_LAT - 1; i++) dat_q[i] <= dat_d[i];
         end
      end
   end

   // Output stage holds its value unless a valid read emerges
   always_comb begin
      r_data_d = last_vld ? last_dat : r_data_q;
   end

   // Status and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data_q   <= '0;
         err_q      <= 1'b0;
         wr_count_q <= '0;
         done_q     <= 1'b0;
      end else begin
         r_data_q   <= r_data_d;
         err_q      <= err_d;
         wr_count_q <= wr_count_d;
         done_q     <= done_d;
      end
   end

   assign R_data   = r_data_q;
   assign err      = err_q;
   assign wr_count = wr_count_q;
   assign done     = done_q;

endmodule

// File: tb/tb_conv_mem_slave.sv
// Bench for conv_mem_slave: three instances (RD_LAT 1, 2, 3) share one input
// stream and are compared against a history-based memory model.
module tb_conv_mem_slave;

   localparam int unsigned DEPTH     = 1024;
   localparam int unsigned EXPECT_WR = 676;
   localparam int          HN        = 8192;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        R_req = 1'b0;
   logic [31:0] addr = '0;
   logic [3:0]  W_req = '0;
   logic [31:0] W_data = '0;
   logic        ld_en = 1'b0;
   logic [9:0]  ld_idx = '0;
   logic [31:0] ld_data = '0;

   logic [31:0] r1, r2, r3;
   logic        e1, e2, e3, d1, d2, d3;
   logic [15:0] c1, c2, c3;

   int checks = 0;
   int errors = 0;

   // model state
   bit [31:0] mm [DEPTH];
   bit        hv [HN];
   bit [31:0] hd [HN];
   bit [31:0] exp_r [4];
   bit        m_err;
   int        m_cnt;
   bit        m_done;
   int        cyc = 0;
   int        rst_cyc = -1;

   always #5 clk = ~clk;

   conv_mem_slave #(.DEPTH(DEPTH), .RD_LAT(1), .EXPECT_WR(EXPECT_WR)) u_lat1 (
      .clk(clk), .rst(rst), .R_req(R_req), .addr(addr), .R_data(r1),
      .W_req(W_req), .W_data(W_data), .ld_en(ld_en), .ld_idx(ld_idx),
      .ld_data(ld_data), .err(e1), .wr_count(c1), .done(d1));

   conv_mem_slave #(.DEPTH(DEPTH), .RD_LAT(2), .EXPECT_WR(EXPECT_WR)) u_lat2 (
      .clk(clk), .rst(rst), .R_req(R_req), .addr(addr), .R_data(r2),
      .W_req(W_req), .W_data(W_data), .ld_en(ld_en), .ld_idx(ld_idx),
      .ld_data(ld_data), .err(e2), .wr_count(c2), .done(d2));

   conv_mem_slave #(.DEPTH(DEPTH), .RD_LAT(3), .EXPECT_WR(EXPECT_WR)) u_lat3 (
      .clk(clk), .rst(rst), .R_req(R_req), .addr(addr), .R_data(r3),
      .W_req(W_req), .W_data(W_data), .ld_en(ld_en), .ld_idx(ld_idx),
      .ld_data(ld_data), .err(e3), .wr_count(c3), .done(d3));

   // Apply the current inputs to the model, then advance one clock edge.
   task automatic tick();
      bit lg;
      int unsigned wi;
      int k;
      lg = (addr[1:0] == 2'b00) && (addr[31:2] < DEPTH);
      wi = addr[31:2];
      if (rst) begin
         m_err = 0; m_cnt = 0; m_done = 0;
         for (int l = 1; l <= 3; l++) exp_r[l] = '0;
         rst_cyc = cyc;
         hv[cyc % HN] = 0;
      end else begin
         hv[cyc % HN] = R_req;
         hd[cyc % HN] = lg ? mm[wi] : 32'h0;
         if ((R_req || W_req != 0) && !lg) m_err = 1;
         if (ld_en && ld_idx >= DEPTH) m_err = 1;
         if (W_req != 0 && lg) begin
            if (!(ld_en && ld_idx == wi))
               for (int b = 0; b < 4; b++)
                  if (W_req[b]) mm[wi][8*b +: 8] = W_data[8*b +: 8];
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt >= EXPECT_WR) m_done = 1;
         end
         if (ld_en && ld_idx < DEPTH) mm[ld_idx] = ld_data;
         for (int l = 1; l <= 3; l++) begin
            k = cyc - (l - 1);
            if (k > rst_cyc && k >= 0 && hv[k % HN]) exp_r[l] = hd[k % HN];
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle();
      R_req = 0; W_req = 0; ld_en = 0;
   endtask

   task automatic test_reset();
      rst = 1; idle();
      tick(); tick();
      rst = 0;
      checks++; if (r1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1 got %h exp 0", r1); end
      checks++; if (r3 !== 32'h0) begin errors++; $display("FAIL reset_rdata3 got %h exp 0", r3); end
      checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", e1); end
      checks++; if (c1 !== 16'h0) begin errors++; $display("FAIL reset_count got %0d exp 0", c1); end
      checks++; if (d1 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", d1); end
   endtask

   task automatic test_preload_all();
      ld_en = 1;
      for (int i = 0; i < DEPTH; i++) begin
         ld_idx  = 10'(i);
         ld_data = (i == 5) ? 32'hDEADBEEF : (i == 2) ? 32'h11223344 :
                   (i == 3) ? 32'h1 : $urandom;
         tick();
      end
      idle();
      checks++; if (c1 !== 16'h0) begin errors++; $display("FAIL preload_count got %0d exp 0", c1); end
   endtask

   task automatic test_preload_read();
      R_req = 1; addr = 32'd20;
      tick();
      idle();
      checks++; if (r1 !== 32'hDEADBEEF) begin errors++; $display("FAIL pr_lat1 got %h exp deadbeef", r1); end
      checks++; if (r3 !== 32'h0) begin errors++; $display("FAIL pr_lat3_early got %h exp 0", r3); end
      tick();
      checks++; if (r2 !== 32'hDEADBEEF) begin errors++; $display("FAIL pr_lat2 got %h exp deadbeef", r2); end
      checks++; if (r3 !== 32'h0) begin errors++; $display("FAIL pr_lat3_mid got %h exp 0", r3); end
      tick();
      checks++; if (r3 !== 32'hDEADBEEF) begin errors++; $display("FAIL pr_lat3 got %h exp deadbeef", r3); end
      tick();
      checks++; if (r1 !== 32'hDEADBEEF) begin errors++; $display("FAIL pr_hold got %h exp deadbeef", r1); end
   endtask

   task automatic test_byte_strobes();
      W_req = 4'b0101; addr = 32'd8; W_data = 32'hAABBCCDD;
      tick();
      idle(); R_req = 1;
      tick();
      idle();
      checks++; if (r1 !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_data got %h exp 11bb33dd", r1); end
      checks++; if (c1 !== 16'd1) begin errors++; $display("FAIL strobe_count got %0d exp 1", c1); end
   endtask

   task automatic test_collision();
      R_req = 1; W_req = 4'hF; addr = 32'd12; W_data = 32'h2;
      tick();
      W_req = 0;
      checks++; if (r1 !== 32'h1) begin errors++; $display("FAIL coll_readfirst got %h exp 1", r1); end
      tick();
      idle();
      checks++; if (r1 !== 32'h2) begin errors++; $display("FAIL coll_next got %h exp 2", r1); end
   endtask

   task automatic test_illegal();
      logic [15:0] cnt0;
      logic [31:0] w1;
      cnt0 = c1;
      w1 = mm[1];
      W_req = 4'hF; addr = 32'h6; W_data = 32'h55AA55AA;
      tick();
      idle();
      checks++; if (e1 !== 1'b1) begin errors++; $display("FAIL ill_err got %b exp 1", e1); end
      checks++; if (c1 !== cnt0) begin errors++; $display("FAIL ill_count got %0d exp %0d", c1, cnt0); end
      R_req = 1; addr = DEPTH * 4;
      tick();
      checks++; if (r1 !== 32'h0) begin errors++; $display("FAIL ill_rdata got %h exp 0", r1); end
      addr = 32'd4;
      tick();
      idle();
      checks++; if (r1 !== w1) begin errors++; $display("FAIL ill_array got %h exp %h", r1, w1); end
   endtask

   task automatic test_random();
      int unsigned w;
      for (int n = 0; n < 400; n++) begin
         R_req  = 1'($urandom_range(0, 1));
         W_req  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
         W_data = $urandom;
         w      = $urandom_range(0, DEPTH - 1);
         case ($urandom_range(0, 11))
            0:       addr = (w << 2) | 32'd2;
            1:       addr = DEPTH * 4 + (w << 2);
            default: addr = w << 2;
         endcase
         ld_en   = ($urandom_range(0, 3) == 0);
         ld_idx  = ($urandom_range(0, 1) == 1) ? addr[11:2] : 10'($urandom);
         ld_data = $urandom;
         tick();
         checks++; if (r1 !== exp_r[1]) begin errors++; $display("FAIL rnd_r1 n=%0d got %h exp %h", n, r1, exp_r[1]); end
         checks++; if (r2 !== exp_r[2]) begin errors++; $display("FAIL rnd_r2 n=%0d got %h exp %h", n, r2, exp_r[2]); end
         checks++; if (r3 !== exp_r[3]) begin errors++; $display("FAIL rnd_r3 n=%0d got %h exp %h", n, r3, exp_r[3]); end
         checks++; if (e2 !== m_err) begin errors++; $display("FAIL rnd_err n=%0d got %b exp %b", n, e2, m_err); end
         checks++; if (c3 !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_cnt n=%0d got %0d exp %0d", n, c3, m_cnt); end
         checks++; if (d1 !== m_done) begin errors++; $display("FAIL rnd_done n=%0d got %b exp %b", n, d1, m_done); end
      end
      idle();
   endtask

   task automatic test_back_to_back();
      R_req = 1;
      for (int n = 0; n < 12; n++) begin
         addr = 32'(n * 4);
         tick();
         checks++; if (r1 !== exp_r[1]) begin errors++; $display("FAIL b2b_r1 n=%0d got %h exp %h", n, r1, exp_r[1]); end
         checks++; if (r2 !== exp_r[2]) begin errors++; $display("FAIL b2b_r2 n=%0d got %h exp %h", n, r2, exp_r[2]); end
         checks++; if (r3 !== exp_r[3]) begin errors++; $display("FAIL b2b_r3 n=%0d got %h exp %h", n, r3, exp_r[3]); end
      end
      idle();
   endtask

   task automatic test_completion();
      rst = 1; tick(); rst = 0;
      W_req = 4'hF;
      for (int i = 1; i <= EXPECT_WR + 1; i++) begin
         addr = 32'((i - 1) * 4); W_data = $urandom;
         tick();
         if (i >= EXPECT_WR - 1) begin
            checks++;
            if (d1 !== (i >= EXPECT_WR)) begin errors++; $display("FAIL done_edge i=%0d got %b exp %b", i, d1, (i >= EXPECT_WR)); end
         end
      end
      idle();
      checks++; if (c1 !== 16'(EXPECT_WR + 1)) begin errors++; $display("FAIL done_count got %0d exp %0d", c1, EXPECT_WR + 1); end
      checks++; if (d2 !== 1'b1) begin errors++; $display("FAIL done_sticky got %b exp 1", d2); end
   endtask

   task automatic test_reset_midstream();
      W_req = 4'hF; addr = 32'd28; W_data = 32'hCAFE0001;
      tick();
      W_req = 0; R_req = 1;
      tick();
      R_req = 0; rst = 1;
      tick();
      rst = 0;
      for (int n = 0; n < 3; n++) begin
         checks++; if (r2 !== 32'h0) begin errors++; $display("FAIL mid_r2 n=%0d got %h exp 0", n, r2); end
         checks++; if (r3 !== 32'h0) begin errors++; $display("FAIL mid_r3 n=%0d got %h exp 0", n, r3); end
         tick();
      end
      checks++; if (r1 !== 32'h0) begin errors++; $display("FAIL mid_r1 got %h exp 0", r1); end
      checks++; if (c2 !== 16'h0 || e2 !== 1'b0 || d2 !== 1'b0) begin errors++; $display("FAIL mid_status got %0d/%b/%b exp 0/0/0", c2, e2, d2); end
      R_req = 1;
      tick();
      idle();
      checks++; if (r1 !== 32'hCAFE0001) begin errors++; $display("FAIL mid_persist got %h exp cafe0001", r1); end
   endtask

   initial begin
      test_reset();
      test_preload_all();
      test_preload_read();
      test_byte_strobes();
      test_collision();
      test_illegal();
      test_random();
      test_back_to_back();
      test_completion();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
